// File: rtl/serial_bit_sequence_encoder.sv
// rtl/serial_bit_sequence_encoder.sv - framed serial encoder: preamble, payload, even parity
//
// Purpose: serialises one DATA_WIDTH payload per accepted load as
//          PREAMBLE (MSB first), payload (MSB first), even-parity bit.
// Ports:
//   clk      in   clock, rising edge
//   n_reset  in   asynchronous active-low reset
//   data_in  in   payload word, captured on an accepted load
//   load     in   frame request, accepted only while ready=1
//   ready    out  1 when a load will be accepted (IDLE)
//   out_bit  out  registered serial bit stream
//   busy     out  1 while a frame is on out_bit
//   done     out  one-cycle pulse in the first IDLE clock after parity
module serial_bit_sequence_encoder #(
    parameter int                      DATA_WIDTH   = 8,
    parameter int                      PREAMBLE_LEN = 4,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = 4'b1110
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_MAX = (PREAMBLE_LEN > DATA_WIDTH) ? PREAMBLE_LEN : DATA_WIDTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_PARITY   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [PREAMBLE_LEN-1:0] r_pre;
    logic                    r_parity;
    logic                    r_out_bit;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_done;

    // Each state emits its first bit on the edge that enters it, so the
    // counter records how many bits of the current state have already been
    // shown; the last bit is on the wire when r_cnt reaches LEN-1.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_pre     <= '0;
            r_parity  <= 1'b0;
            r_out_bit <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done    <= 1'b0;
                    r_out_bit <= 1'b0;
                    if (load) begin
                        // First preamble bit goes out on the accepting edge.
                        r_state   <= ST_PREAMBLE;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_out_bit <= PREAMBLE[PREAMBLE_LEN-1];
                        r_pre     <= PREAMBLE << 1;
                        r_shift   <= data_in;
                        r_parity  <= ^data_in;
                        r_cnt     <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_cnt == CW'(PREAMBLE_LEN - 1)) begin
                        r_state   <= ST_DATA;
                        r_out_bit <= r_shift[DATA_WIDTH-1];
                        r_shift   <= r_shift << 1;
                        r_cnt     <= '0;
                    end else begin
                        r_out_bit <= r_pre[PREAMBLE_LEN-1];
                        r_pre     <= r_pre << 1;
                        r_cnt     <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                        r_state   <= ST_PARITY;
                        r_out_bit <= r_parity;
                        r_cnt     <= '0;
                    end else begin
                        r_out_bit <= r_shift[DATA_WIDTH-1];
                        r_shift   <= r_shift << 1;
                        r_cnt     <= r_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    r_state   <= ST_IDLE;
                    r_out_bit <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    r_done    <= 1'b1;
                    r_cnt     <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_out_bit <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    r_done    <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign out_bit = r_out_bit;
    assign busy    = r_busy;
    assign ready   = r_ready;
    assign done    = r_done;

endmodule
